// File: rtl/stream_pkg.sv
// Shared encodings for the stream round-robin mux: source ids, arbiter
// states and grant bit positions.
package stream_pkg;

    localparam logic SRC_B = 1'b1;
    localparam logic SRC_C = 1'b0;

    localparam logic [0:0] IDLE_RR = 1'b0;
    localparam logic [0:0] LOCKED  = 1'b1;

    localparam int unsigned GNT_B = 1;
    localparam int unsigned GNT_C = 0;

    function automatic logic [1:0] src_onehot(input logic src);
        return (src == SRC_B) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/stream_rr_mux_if.sv
// Handshake bundle for stream_rr_mux: two input streams (b, c) and one
// merged output stream (a). slave is the mux view, master the driver view.
interface stream_rr_mux_if #(
    parameter int DATA_WD = 4
);
    logic               b_valid;
    logic [DATA_WD-1:0] b_data;
    logic               b_last;
    logic               b_ready;

    logic               c_valid;
    logic [DATA_WD-1:0] c_data;
    logic               c_last;
    logic               c_ready;

    logic               a_valid;
    logic [DATA_WD-1:0] a_data;
    logic               a_last;
    logic               a_src;
    logic               a_ready;

    modport slave (
        input  b_valid, b_data, b_last,
        output b_ready,
        input  c_valid, c_data, c_last,
        output c_ready,
        output a_valid, a_data, a_last, a_src,
        input  a_ready
    );

    modport master (
        output b_valid, b_data, b_last,
        input  b_ready,
        output c_valid, c_data, c_last,
        input  c_ready,
        input  a_valid, a_data, a_last, a_src,
        output a_ready
    );

endinterface

// File: rtl/stream_rr_arb.sv
// Packet-level round-robin arbiter: grants one of two requesters and keeps
// the grant locked to the owner until its last beat is accepted.
module stream_rr_arb
    import stream_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       last,
    input  logic       fire,
    output logic [1:0] grant
);

    logic [0:0] state;
    logic       owner;
    logic       ptr;
    logic       granted_src;

    // Under contention the input that did not own the previous packet wins.
    always_comb begin
        grant = '0;
        if (state == LOCKED) begin
            grant = src_onehot(owner);
        end else if (req == 2'b11) begin
            grant = src_onehot(~ptr);
        end else begin
            grant = req;
        end
    end

    assign granted_src = grant[GNT_B] ? SRC_B : SRC_C;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE_RR;
            owner <= SRC_C;
            ptr   <= SRC_C;
        end else if (fire) begin
            if (last) begin
                state <= IDLE_RR;
                ptr   <= granted_src;
            end else begin
                state <= LOCKED;
                owner <= granted_src;
            end
        end
    end

endmodule

// File: rtl/stream_rr_mux.sv
// Two-input packet round-robin stream mux with a registered one-beat
// output stage; arbitration lives in stream_rr_arb.
module stream_rr_mux
    import stream_pkg::*;
#(
    parameter int DATA_WD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    stream_rr_mux_if.slave   bus
);

    logic [1:0]         grant;
    logic               space;
    logic               b_fire;
    logic               c_fire;
    logic               load;
    logic               sel_last;
    logic [DATA_WD-1:0] sel_data;

    logic               a_valid_q;
    logic [DATA_WD-1:0] a_data_q;
    logic               a_last_q;
    logic               a_src_q;

    // The output slot can take a beat when empty or draining this cycle.
    assign space  = !a_valid_q || bus.a_ready;

    assign bus.b_ready = rst_n && grant[GNT_B] && space;
    assign bus.c_ready = rst_n && grant[GNT_C] && space;

    assign b_fire = bus.b_ready && bus.b_valid;
    assign c_fire = bus.c_ready && bus.c_valid;
    assign load   = b_fire || c_fire;

    assign sel_last = grant[GNT_B] ? bus.b_last : bus.c_last;
    assign sel_data = grant[GNT_B] ? bus.b_data : bus.c_data;

    stream_rr_arb u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   ({bus.b_valid, bus.c_valid}),
        .last  (sel_last),
        .fire  (load),
        .grant (grant)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_valid_q <= 1'b0;
            a_data_q  <= '0;
            a_last_q  <= 1'b0;
            a_src_q   <= SRC_C;
        end else if (load) begin
            a_valid_q <= 1'b1;
            a_data_q  <= sel_data;
            a_last_q  <= sel_last;
            a_src_q   <= grant[GNT_B] ? SRC_B : SRC_C;
        end else if (bus.a_ready) begin
            a_valid_q <= 1'b0;
        end
    end

    assign bus.a_valid = a_valid_q;
    assign bus.a_data  = a_data_q;
    assign bus.a_last  = a_last_q;
    assign bus.a_src   = a_src_q;

endmodule

// File: tb/tb_stream_rr_mux.sv
// Self-checking bench for stream_rr_mux: directed scenarios plus a random
// run checked against a packet-level arbitration model and beat queue.
module tb_stream_rr_mux;

    localparam int DW = 4;

    typedef struct {
        bit          src;
        bit          last;
        logic [DW-1:0] data;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    stream_rr_mux_if #(.DATA_WD(DW)) bus ();

    stream_rr_mux #(.DATA_WD(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad = 0;

    // Model: packet owner lock, last packet owner, beats waiting at the output.
    bit    m_locked;
    bit    m_owner;
    bit    m_ptr;
    beat_t exp_q[$];

    // 2 = B granted, 1 = C granted, 0 = nothing granted
    function automatic int model_grant(input bit bv, input bit cv);
        if (m_locked) return m_owner ? 2 : 1;
        if (bv && cv) return m_ptr ? 1 : 2;
        if (bv) return 2;
        if (cv) return 1;
        return 0;
    endfunction

    function automatic bit model_space();
        return (exp_q.size() == 0) || bus.a_ready;
    endfunction

    task automatic tick();
        int    g;
        bit    bf, cf, af;
        beat_t nb;
        g  = model_grant(bus.b_valid, bus.c_valid);
        bf = rst_n && (g == 2) && model_space() && bus.b_valid;
        cf = rst_n && (g == 1) && model_space() && bus.c_valid;
        af = (exp_q.size() != 0) && bus.a_ready;
        nb.src  = bf;
        nb.last = bf ? bus.b_last : bus.c_last;
        nb.data = bf ? bus.b_data : bus.c_data;
        @(posedge clk);
        if (!rst_n) begin
            exp_q.delete();
            m_locked = 0;
            m_owner  = 0;
            m_ptr    = 0;
        end else begin
            if (af) void'(exp_q.pop_front());
            if (bf || cf) begin
                exp_q.push_back(nb);
                if (nb.last) begin
                    m_locked = 0;
                    m_ptr    = nb.src;
                end else begin
                    m_locked = 1;
                    m_owner  = nb.src;
                end
            end
        end
        #1;
    endtask

    task automatic set_idle();
        bus.b_valid = 0; bus.b_data = '0; bus.b_last = 0;
        bus.c_valid = 0; bus.c_data = '0; bus.c_last = 0;
    endtask

    task automatic do_reset();
        set_idle();
        bus.a_ready = 1;
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        bus.a_ready = 1;
        bus.b_valid = 1; bus.b_data = 4'hF; bus.b_last = 1;
        bus.c_valid = 1; bus.c_data = 4'hE; bus.c_last = 1;
        tick();
        tick();
        total++; if (bus.a_valid !== 1'b0) begin bad++; $display("FAIL reset_a_valid got=%b exp=0", bus.a_valid); end
        total++; if (bus.a_data !== 4'h0) begin bad++; $display("FAIL reset_a_data got=%h exp=0", bus.a_data); end
        total++; if (bus.a_last !== 1'b0) begin bad++; $display("FAIL reset_a_last got=%b exp=0", bus.a_last); end
        total++; if (bus.a_src !== 1'b0) begin bad++; $display("FAIL reset_a_src got=%b exp=0", bus.a_src); end
        total++; if (bus.b_ready !== 1'b0 || bus.c_ready !== 1'b0)
            begin bad++; $display("FAIL reset_ready got=%b%b exp=00", bus.b_ready, bus.c_ready); end
        set_idle();
        rst_n = 1;
    endtask

    task automatic test_single_beat();
        do_reset();
        bus.b_valid = 1; bus.b_data = 4'h5; bus.b_last = 1;
        #1;
        total++; if (bus.b_ready !== 1'b1) begin bad++; $display("FAIL single_b_ready got=%b exp=1", bus.b_ready); end
        tick();
        set_idle();
        total++; if (bus.a_valid !== 1'b1 || bus.a_data !== 4'h5 || bus.a_src !== 1'b1 || bus.a_last !== 1'b1)
            begin bad++; $display("FAIL single_out got=v%b d%h s%b l%b exp=v1 d5 s1 l1",
                bus.a_valid, bus.a_data, bus.a_src, bus.a_last); end
        tick();
        total++; if (bus.a_valid !== 1'b0) begin bad++; $display("FAIL single_drain got=%b exp=0", bus.a_valid); end
    endtask

    task automatic test_alternate();
        do_reset();
        bus.b_valid = 1; bus.b_last = 1;
        bus.c_valid = 1; bus.c_last = 1;
        for (int i = 0; i < 6; i++) begin
            bus.b_data = DW'(i);
            bus.c_data = DW'(i + 8);
            #1;
            total++; if (bus.b_ready && bus.c_ready) begin bad++; $display("FAIL alt_both_ready cycle=%0d", i); end
            tick();
            total++; if (bus.a_valid !== 1'b1 || bus.a_src !== ((i % 2) == 0))
                begin bad++; $display("FAIL alt_src cycle=%0d got=v%b s%b exp=v1 s%0d",
                    i, bus.a_valid, bus.a_src, (i % 2) == 0); end
        end
        set_idle();
        tick();
    endtask

    task automatic test_locked_packet();
        logic [DW-1:0] bseq [3];
        bseq[0] = 4'h1; bseq[1] = 4'h2; bseq[2] = 4'h3;
        do_reset();
        bus.c_valid = 1; bus.c_data = 4'h9; bus.c_last = 1;
        for (int i = 0; i < 3; i++) begin
            bus.b_valid = 1; bus.b_data = bseq[i]; bus.b_last = (i == 2);
            #1;
            total++; if (bus.c_ready !== 1'b0 || bus.b_ready !== 1'b1)
                begin bad++; $display("FAIL lock_ready beat=%0d got=b%b c%b exp=b1 c0", i, bus.b_ready, bus.c_ready); end
            tick();
            total++; if (bus.a_data !== bseq[i] || bus.a_src !== 1'b1)
                begin bad++; $display("FAIL lock_out beat=%0d got=d%h s%b exp=d%h s1", i, bus.a_data, bus.a_src, bseq[i]); end
            if (i == 0) begin
                // Owner B idles mid-packet: C must still be held off.
                bus.b_valid = 0;
                #1;
                total++; if (bus.c_ready !== 1'b0)
                    begin bad++; $display("FAIL lock_gap_c_ready got=%b exp=0", bus.c_ready); end
                tick();
            end
        end
        bus.b_valid = 0;
        #1;
        total++; if (bus.c_ready !== 1'b1) begin bad++; $display("FAIL lock_release_c_ready got=%b exp=1", bus.c_ready); end
        tick();
        set_idle();
        total++; if (bus.a_valid !== 1'b1 || bus.a_data !== 4'h9 || bus.a_src !== 1'b0)
            begin bad++; $display("FAIL lock_c_out got=v%b d%h s%b exp=v1 d9 s0", bus.a_valid, bus.a_data, bus.a_src); end
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.b_valid = 1; bus.b_data = 4'h7; bus.b_last = 1;
        tick();
        bus.a_ready = 0;
        bus.b_data = 4'hA;
        bus.c_valid = 1; bus.c_data = 4'hB; bus.c_last = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if (bus.a_valid !== 1'b1 || bus.a_data !== 4'h7 || bus.b_ready !== 1'b0 || bus.c_ready !== 1'b0)
                begin bad++; $display("FAIL bp_hold cycle=%0d got=v%b d%h br%b cr%b exp=v1 d7 br0 cr0",
                    i, bus.a_valid, bus.a_data, bus.b_ready, bus.c_ready); end
            tick();
        end
        bus.a_ready = 1;
        tick();
        set_idle();
        total++; if (bus.a_valid !== 1'b1 || bus.a_data !== 4'hB || bus.a_src !== 1'b0)
            begin bad++; $display("FAIL bp_no_bubble got=v%b d%h s%b exp=v1 dB s0", bus.a_valid, bus.a_data, bus.a_src); end
        tick();
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        bus.c_valid = 1; bus.c_last = 0;
        bus.c_data = 4'h1; tick();
        bus.c_data = 4'h2; tick();
        bus.c_data = 4'h3;
        rst_n = 0;
        tick();
        total++; if (bus.a_valid !== 1'b0) begin bad++; $display("FAIL midrst_a_valid got=%b exp=0", bus.a_valid); end
        rst_n = 1;
        bus.c_last = 1; bus.c_data = 4'h4;
        bus.b_valid = 1; bus.b_last = 1; bus.b_data = 4'h6;
        #1;
        total++; if (bus.b_ready !== 1'b1 || bus.c_ready !== 1'b0)
            begin bad++; $display("FAIL midrst_ready got=b%b c%b exp=b1 c0", bus.b_ready, bus.c_ready); end
        tick();
        set_idle();
        total++; if (bus.a_src !== 1'b1 || bus.a_data !== 4'h6)
            begin bad++; $display("FAIL midrst_winner got=s%b d%h exp=s1 d6", bus.a_src, bus.a_data); end
        tick();
    endtask

    task automatic test_random();
        int    g;
        beat_t f;
        do_reset();
        for (int i = 0; i < 500; i++) begin
            bus.b_valid = 1'($urandom_range(0, 1));
            bus.b_data  = DW'($urandom);
            bus.b_last  = ($urandom_range(0, 2) == 0);
            bus.c_valid = 1'($urandom_range(0, 1));
            bus.c_data  = DW'($urandom);
            bus.c_last  = ($urandom_range(0, 2) == 0);
            bus.a_ready = ($urandom_range(0, 3) != 0);
            #1;
            g = model_grant(bus.b_valid, bus.c_valid);
            total++; if (bus.b_ready !== ((g == 2) && model_space()) || bus.c_ready !== ((g == 1) && model_space()))
                begin bad++; $display("FAIL rand_ready cycle=%0d got=b%b c%b exp=b%0d c%0d", i, bus.b_ready, bus.c_ready,
                    (g == 2) && model_space(), (g == 1) && model_space()); end
            total++; if (bus.a_valid !== (exp_q.size() != 0))
                begin bad++; $display("FAIL rand_a_valid cycle=%0d got=%b exp=%0d", i, bus.a_valid, exp_q.size() != 0); end
            if (exp_q.size() != 0) begin
                f = exp_q[0];
                total++; if (bus.a_data !== f.data || bus.a_last !== f.last || bus.a_src !== f.src)
                    begin bad++; $display("FAIL rand_beat cycle=%0d got=d%h l%b s%b exp=d%h l%b s%b", i,
                        bus.a_data, bus.a_last, bus.a_src, f.data, f.last, f.src); end
            end
            tick();
        end
        set_idle();
        bus.a_ready = 1;
        tick();
    endtask

    initial begin
        set_idle();
        bus.a_ready = 1;
        m_locked = 0; m_owner = 0; m_ptr = 0;
        test_reset();
        test_single_beat();
        test_alternate();
        test_locked_packet();
        test_backpressure();
        test_reset_mid_packet();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_rr_mux.md
STREAM_RR_MUX -- requirements
Module: stream_rr_mux

Interface
REQ-001 The module SHALL have parameter DATA_WD, default 4, meaning the payload width in bits.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all logic on the rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-004 The module SHALL have port b_valid, input, 1 bit: input B beat valid.
REQ-005 The module SHALL have port b_data, input, DATA_WD bits: input B payload.
REQ-006 The module SHALL have port b_last, input, 1 bit: input B end-of-packet marker.
REQ-007 The module SHALL have port b_ready, output, 1 bit: input B accept.
REQ-008 The module SHALL have port c_valid, input, 1 bit: input C beat valid.
REQ-009 The module SHALL have port c_data, input, DATA_WD bits: input C payload.
REQ-010 The module SHALL have port c_last, input, 1 bit: input C end-of-packet marker.
REQ-011 The module SHALL have port c_ready, output, 1 bit: input C accept.
REQ-012 The module SHALL have port a_valid, output, 1 bit: merged output beat valid.
REQ-013 The module SHALL have port a_data, output, DATA_WD bits: merged output payload.
REQ-014 The module SHALL have port a_last, output, 1 bit: merged end-of-packet marker.
REQ-015 The module SHALL have port a_src, output, 1 bit: source of the current a beat (1 = B, 0 = C).
REQ-016 The module SHALL have port a_ready, input, 1 bit: downstream accept.

Function
REQ-017 A beat SHALL transfer on any port in a cycle where valid and ready are both 1 (fire).
REQ-018 a_valid, a_data, a_last and a_src SHALL be registered outputs, one-beat pipeline stage, latency 1 cycle from input fire to a_valid.
REQ-019 The load enable SHALL be (!a_valid || a_ready) AND (granted input valid); a_* SHALL update only on load.
REQ-020 When a_valid=1 and a_ready=0, a_data, a_last and a_src SHALL hold stable.
REQ-021 a_valid SHALL clear after an a fire in which no new beat loads.
REQ-022 With a_ready held 1 and an input continuously valid, throughput SHALL be one beat per cycle.
REQ-023 b_ready SHALL be 1 only when grant = B and (!a_valid || a_ready); c_ready likewise for C; b_ready and c_ready SHALL never both be 1.
REQ-024 Arbiter states SHALL be IDLE_RR (unlocked) and LOCKED (owner B or C).
REQ-025 In IDLE_RR, if exactly one input is valid it SHALL be granted; if both are valid, the input other than the pointer (last packet owner) SHALL be granted.
REQ-026 An accepted beat with last=0 in IDLE_RR SHALL move to LOCKED with owner = that source.
REQ-027 In LOCKED, only the owner SHALL be granted, even if the other input is valid and the owner is not.
REQ-028 An accepted beat with last=1 SHALL return to IDLE_RR and set the pointer to that source.
REQ-029 A single-beat packet (last=1 on first beat) SHALL not enter LOCKED but SHALL update the pointer.
REQ-030 Output drain and a new load in the same cycle SHALL both occur, without a bubble.
REQ-031 Valid from the module SHALL not depend combinationally on a_ready; ready outputs MAY depend on input valid.

Reset
REQ-032 On a clk edge with rst_n=0, a_valid SHALL be 0, a_data all-zero, a_last 0, a_src 0.
REQ-033 On reset, the arbiter SHALL be IDLE_RR and the pointer = C, so B wins the first contention.
REQ-034 During reset, b_ready and c_ready SHALL be 0.
REQ-035 A reset mid-packet SHALL discard the held output beat and clear the lock; no partial state survives.

Structure
REQ-036 Source encodings (SRC_B=1, SRC_C=0) and arbiter state encodings SHALL live in the shared package stream_pkg.
REQ-037 Arbitration and lock SHALL be a sub-module stream_rr_arb, with inputs req[1:0], last, fire and outputs grant[1:0]; stream_rr_mux holds the output register.

Verification
REQ-038 Reset then B sends a 1-beat packet 0x5 (last=1), a_ready=1 -> a_valid=1 next cycle, a_data=0x5, a_src=1, a_last=1.
REQ-039 B and C both valid every cycle with single-beat packets, a_ready=1 -> a_src alternates 1,0,1,0 starting with 1.
REQ-040 B sends a 3-beat packet 0x1,0x2,0x3 while C is valid with 0x9 -> output is 0x1,0x2,0x3 (src=1), then 0x9 (src=0); c_ready=0 throughout the B packet.
REQ-041 Output 0x7 is held while a_ready=0 for 4 cycles -> a_data stays 0x7, b_ready=c_ready=0; a_ready=1 -> the next beat appears the following cycle with no bubble.
REQ-042 rst_n=0 after beat 2 of a 3-beat C packet -> a_valid=0 next cycle; after release, B wins contention against C.
